// File: rtl/sm_key_pkg.sv
// Shared constants for the board key capture block: status-word field offsets
// and the maximum key count the 8-bit fields can hold.
package sm_key_pkg;

  localparam int STATE_LSB   = 0;
  localparam int PRESS_LSB   = 8;
  localparam int RELEASE_LSB = 16;
  localparam int MAX_KEYS    = 8;

endpackage

// File: rtl/sm_debounce.sv
// One board key: 2-flop synchronizer, stability counter and debounced level,
// with registered one-cycle rise/fall pulses coincident with the level change.
module sm_debounce
  import sm_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RELEASED = ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             pressed;

  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES,
  // so the counter itself never has to hold that value.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pressed = sync2_q ^ ACTIVE_LOW;
    if (pressed != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ~state_q;
        rise_d  = ~state_q;
        fall_d  = state_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sm_key_input.sv
// Board key capture: debounced levels, press pulses and sticky W1C events in a
// 32-bit status word. Release events are built only with SM_KEY_RELEASE_EVENT_EN.
module sm_key_input
  import sm_key_pkg::*;
#(
  parameter int          KEY_WIDTH       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] keyIn,
  input  logic [KEY_WIDTH-1:0] evClr,
  output logic [KEY_WIDTH-1:0] keyState,
  output logic [KEY_WIDTH-1:0] keyPress,
  output logic [31:0]          regData
);

  logic [KEY_WIDTH-1:0] level_w;
  logic [KEY_WIDTH-1:0] rise_w;
  logic [KEY_WIDTH-1:0] fall_w;
  logic [KEY_WIDTH-1:0] press_ev_q, press_ev_d;

  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
    sm_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_raw(keyIn[i]),
      .level  (level_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  // The pulse is ORed into the visible bit so the event shows in the pulse
  // cycle, and re-loads the flop so a clear in that same cycle loses.
  always_comb begin
    press_ev_d = (press_ev_q & ~evClr) | rise_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_ev_q <= '0;
    end else begin
      press_ev_q <= press_ev_d;
    end
  end

`ifdef SM_KEY_RELEASE_EVENT_EN
  logic [KEY_WIDTH-1:0] release_ev_q, release_ev_d;

  always_comb begin
    release_ev_d = (release_ev_q & ~evClr) | fall_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      release_ev_q <= '0;
    end else begin
      release_ev_q <= release_ev_d;
    end
  end
`else
  logic fall_unused;
  assign fall_unused = ^fall_w;
`endif

  always_comb begin
    regData = '0;
    regData[STATE_LSB +: KEY_WIDTH] = level_w;
    regData[PRESS_LSB +: KEY_WIDTH] = press_ev_q | rise_w;
`ifdef SM_KEY_RELEASE_EVENT_EN
    regData[RELEASE_LSB +: KEY_WIDTH] = release_ev_q | fall_w;
`endif
  end

  assign keyState = level_w;
  assign keyPress = rise_w;

endmodule

// File: tb/tb_sm_key_input.sv
// Self-checking bench for sm_key_input (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, two
// keys); honours SM_KEY_RELEASE_EVENT_EN for the release-event field.
module tb_sm_key_input;

  localparam int KW = 2;
  localparam int DC = 4;
  localparam bit AL = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic [KW-1:0] keyIn;
  logic [KW-1:0] evClr;
  logic [KW-1:0] keyState;
  logic [KW-1:0] keyPress;
  logic [31:0]   regData;

  int checkCount = 0;
  int errorCount = 0;

  sm_key_input #(
    .KEY_WIDTH      (KW),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .keyIn   (keyIn),
    .evClr   (evClr),
    .keyState(keyState),
    .keyPress(keyPress),
    .regData (regData)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples travel through a two-entry pipe; a key's
  // level flips once DC consecutive synchronized samples disagree with it.
  bit [1:0] pipeQ [KW];
  int       runLen [KW];
  bit       mLevel [KW];
  bit       mRise [KW];
  bit       mFall [KW];
  bit       mPressEv [KW];
  bit       mReleaseEv [KW];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelReg();
    logic [31:0] w = '0;
    for (int i = 0; i < KW; i++) begin
      w[i]     = mLevel[i];
      w[8 + i] = mPressEv[i];
`ifdef SM_KEY_RELEASE_EVENT_EN
      w[16 + i] = mReleaseEv[i];
`endif
    end
    return w;
  endfunction

  function automatic logic [KW-1:0] modelLevel();
    logic [KW-1:0] v = '0;
    for (int i = 0; i < KW; i++) v[i] = mLevel[i];
    return v;
  endfunction

  function automatic logic [KW-1:0] modelPress();
    logic [KW-1:0] v = '0;
    for (int i = 0; i < KW; i++) v[i] = mRise[i];
    return v;
  endfunction

  task automatic modelEdge(input bit r, input bit [KW-1:0] raw, input bit [KW-1:0] clr);
    bit seenPressed;
    bit newRise;
    bit newFall;
    for (int i = 0; i < KW; i++) begin
      if (r) begin
        pipeQ[i]      = {AL, AL};
        runLen[i]     = 0;
        mLevel[i]     = 1'b0;
        mRise[i]      = 1'b0;
        mFall[i]      = 1'b0;
        mPressEv[i]   = 1'b0;
        mReleaseEv[i] = 1'b0;
      end else begin
        seenPressed = (pipeQ[i][1] != AL);
        newRise = 1'b0;
        newFall = 1'b0;
        if (seenPressed != mLevel[i]) begin
          runLen[i] = runLen[i] + 1;
          if (runLen[i] == DC) begin
            runLen[i] = 0;
            newRise   = !mLevel[i];
            newFall   = mLevel[i];
            mLevel[i] = !mLevel[i];
          end
        end else begin
          runLen[i] = 0;
        end
        mPressEv[i]   = newRise | (mPressEv[i] & !(clr[i] & !mRise[i]));
        mReleaseEv[i] = newFall | (mReleaseEv[i] & !(clr[i] & !mFall[i]));
        mRise[i] = newRise;
        mFall[i] = newFall;
        pipeQ[i] = {pipeQ[i][0], raw[i]};
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit [KW-1:0] raw, input bit [KW-1:0] clr);
    rst   = r;
    keyIn = raw;
    evClr = clr;
    @(posedge clk);
    modelEdge(r, raw, clr);
    @(negedge clk);
    checkOutput("keyState", 32'(keyState), 32'(modelLevel()));
    checkOutput("keyPress", 32'(keyPress), 32'(modelPress()));
    checkOutput("regData", regData, modelReg());
  endtask

  bit [KW-1:0] rawR;
  bit [KW-1:0] clrR;
  int          holdLeft [KW];

  initial begin
    rst   = 1'b1;
    keyIn = 2'b11;
    evClr = 2'b00;

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'b11, 2'b00);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 2'b11, 2'b00);
      checkOutput("resetRegData", regData, 32'h0);
      checkOutput("resetKeyPress", 32'(keyPress), 32'h0);
    end

    // Clean press on key 0: accepted on the 6th edge, one-cycle pulse.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 2'b10, 2'b00);
      if (k == 5) checkOutput("pressNotEarly", 32'(keyState), 32'h0);
      if (k == 6) begin
        checkOutput("pressLevel", 32'(keyState), 32'h1);
        checkOutput("pressPulse", 32'(keyPress), 32'h1);
        checkOutput("pressReg", regData, 32'h0000_0101);
      end
      if (k == 7) checkOutput("pressPulseOnce", 32'(keyPress), 32'h0);
    end

    // Glitch on key 1 shorter than the debounce window.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 2'b10, 2'b00);
      checkOutput("glitchPulse", 32'(keyPress[1]), 32'h0);
    end
    checkOutput("glitchReg", regData, 32'h0000_0101);

    applyStimulus(1'b0, 2'b10, 2'b01);
    checkOutput("clearEvent", regData, 32'h0000_0001);
    applyStimulus(1'b0, 2'b10, 2'b01);
    checkOutput("clearIdle", regData, 32'h0000_0001);

    // Release key 0.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 2'b11, 2'b00);
      checkOutput("releaseNoPulse", 32'(keyPress), 32'h0);
      if (k == 5) checkOutput("releaseNotEarly", 32'(keyState), 32'h1);
      if (k == 6) begin
        checkOutput("releaseLevel", 32'(keyState), 32'h0);
`ifdef SM_KEY_RELEASE_EVENT_EN
        checkOutput("releaseEvent", 32'(regData[23:16]), 32'h1);
`else
        checkOutput("releaseField", 32'(regData[23:16]), 32'h0);
`endif
      end
    end
    applyStimulus(1'b0, 2'b11, 2'b01);

    // Re-press key 0 with the clear strobe landing in the pulse cycle.
    for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 2'b10, 2'b00);
    checkOutput("collisionPulse", 32'(keyPress), 32'h1);
    applyStimulus(1'b0, 2'b10, 2'b01);
    checkOutput("collisionSetWins", 32'(regData[8]), 32'h1);

    // Reset in the middle of a debounce discards the progress.
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 2'b11, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b00);
    applyStimulus(1'b1, 2'b10, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 2'b10, 2'b00);
      if (k == 5) checkOutput("midResetNotEarly", 32'(keyState), 32'h0);
      if (k == 6) checkOutput("midResetLevel", 32'(keyState), 32'h1);
    end

    // Random key activity with occasional clears and resets.
    rawR = 2'b11;
    for (int i = 0; i < KW; i++) holdLeft[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < KW; i++) begin
        holdLeft[i] = holdLeft[i] - 1;
        if (holdLeft[i] <= 0) begin
          rawR[i]     = !rawR[i];
          holdLeft[i] = int'($urandom_range(1, 10));
        end
      end
      clrR = ($urandom_range(0, 5) == 0) ? KW'($urandom) : '0;
      applyStimulus($urandom_range(0, 299) == 0, rawR, clrR);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
